// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// imm_gen_pipe
//   Registered immediate generator for the RV32I/RV64I decode stage.
//   Each accepted instruction is classified, its immediate is sign- or
//   zero-extended to XLEN bits, and the result lands in a 2-entry FIFO.
//   Unknown opcodes are flagged and counted by a saturating counter.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     instr is valid this cycle
//   in_ready     block can accept an instruction (count < 2)
//   instr        raw 32-bit instruction word
//   out_valid    FIFO head holds a result
//   out_ready    consumer takes the head this cycle
//   imm          XLEN-bit extended immediate of the head entry
//   fmt          head format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
//   illegal      head entry had an unrecognised opcode
//   illegal_cnt  saturating count of accepted illegal instructions
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/instr and out_ready may change freely while no
// transfer happens. in_ready and out_valid depend only on registered state,
// so there is no combinational path from out_ready to in_ready. Head outputs
// stay constant until the cycle the head is popped.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  // ---------------------------------------------------------------- decode
  logic [XLEN-1:0] imm_d;
  logic [2:0]      fmt_d;
  logic            ill_d;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm_d = '0;
    fmt_d = FMT_NONE;
    ill_d = 1'b0;
    if (instr[1:0] != 2'b11) begin
      ill_d = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD, OP_JALR, OP_SYSTEM: begin
          fmt_d = FMT_I;
          imm_d = XLEN'($signed(instr[31:20]));
        end
        OP_IMM: begin
          if (is_shift) begin
            // RV64 shifts use a 6-bit shamt; funct6/funct7 are not immediate.
            fmt_d = FMT_SHAMT;
            if (XLEN == 64) imm_d = XLEN'(instr[25:20]);
            else            imm_d = XLEN'(instr[24:20]);
          end else begin
            fmt_d = FMT_I;
            imm_d = XLEN'($signed(instr[31:20]));
          end
        end
        OP_IMM32: begin
          if (XLEN == 64) begin
            if (is_shift) begin
              fmt_d = FMT_SHAMT;
              imm_d = XLEN'(instr[24:20]);
            end else begin
              fmt_d = FMT_I;
              imm_d = XLEN'($signed(instr[31:20]));
            end
          end else begin
            ill_d = 1'b1;
          end
        end
        OP_STORE: begin
          fmt_d = FMT_S;
          imm_d = XLEN'($signed({instr[31:25], instr[11:7]}));
        end
        OP_BRANCH: begin
          fmt_d = FMT_B;
          imm_d = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0}));
        end
        OP_LUI, OP_AUIPC: begin
          fmt_d = FMT_U;
          imm_d = XLEN'($signed({instr[31:12], 12'b0}));
        end
        OP_JAL: begin
          fmt_d = FMT_J;
          imm_d = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0}));
        end
        OP_OP, OP_FENCE: begin
          fmt_d = FMT_NONE;
        end
        OP_OP32: begin
          ill_d = (XLEN != 64);
        end
        default: begin
          ill_d = 1'b1;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ fifo
  // Slot 0 is always the head; slot 1 only holds data when count == 2.
  logic [1:0]      count;
  logic [XLEN-1:0] head_imm, tail_imm;
  logic [2:0]      head_fmt, tail_fmt;
  logic            head_ill, tail_ill;
  logic            push, pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= 2'd0;
      head_imm    <= '0;
      head_fmt    <= FMT_NONE;
      head_ill    <= 1'b0;
      tail_imm    <= '0;
      tail_fmt    <= FMT_NONE;
      tail_ill    <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_imm <= imm_d;
            head_fmt <= fmt_d;
            head_ill <= ill_d;
          end else begin
            tail_imm <= imm_d;
            tail_fmt <= fmt_d;
            tail_ill <= ill_d;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_imm <= tail_imm;
          head_fmt <= tail_fmt;
          head_ill <= tail_ill;
          tail_imm <= '0;
          tail_fmt <= FMT_NONE;
          tail_ill <= 1'b0;
          count    <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count == 1: the new entry becomes the head.
          head_imm <= imm_d;
          head_fmt <= fmt_d;
          head_ill <= ill_d;
        end
        default: ;
      endcase
      if (push && ill_d && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign imm     = out_valid ? head_imm : '0;
  assign fmt     = out_valid ? head_fmt : FMT_NONE;
  assign illegal = out_valid & head_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
module tb_imm_gen_pipe;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready;
  logic [31:0] instr;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  logic        rdys, ovs, ills;
  logic [31:0] imms;
  logic [2:0]  fmts;
  logic [1:0]  cnts;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .out_valid(ov32), .out_ready(out_ready), .imm(imm32),
    .fmt(fmt32), .illegal(ill32), .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .out_valid(ov64), .out_ready(out_ready), .imm(imm64),
    .fmt(fmt64), .illegal(ill64), .illegal_cnt(cnt64));

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdys),
    .instr(instr), .out_valid(ovs), .out_ready(out_ready), .imm(imms),
    .fmt(fmts), .illegal(ills), .illegal_cnt(cnts));

  // ------------------------------------------------------------ scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int ill_n32 = 0;
  int ill_n64 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: immediates rebuilt with integer arithmetic on the
  // instruction word, then truncated to the datapath width.
  function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                     output logic [63:0] imm_o,
                                     output logic [2:0] fmt_o,
                                     output logic ill_o);
    longint          si;
    longint unsigned uw;
    longint          v;
    bit              shift;
    si    = $signed(w);
    uw    = {32'b0, w};
    v     = 0;
    fmt_o = 3'd0;
    ill_o = 1'b0;
    shift = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
    if (w[1:0] != 2'b11) ill_o = 1'b1;
    else begin
      case (w[6:0])
        7'h03, 7'h67, 7'h73: begin fmt_o = 3'd1; v = si >>> 20; end
        7'h13: begin
          if (shift) begin
            fmt_o = 3'd6;
            v = longint'((uw >> 20) % ((xlen == 64) ? 64 : 32));
          end else begin fmt_o = 3'd1; v = si >>> 20; end
        end
        7'h1B: begin
          if (xlen != 64) ill_o = 1'b1;
          else if (shift) begin fmt_o = 3'd6; v = longint'((uw >> 20) % 32); end
          else begin fmt_o = 3'd1; v = si >>> 20; end
        end
        7'h23: begin fmt_o = 3'd2; v = (si >>> 25) * 32 + longint'((uw >> 7) % 32); end
        7'h63: begin
          fmt_o = 3'd3;
          v = (si >>> 31) * 4096 + longint'(((uw >> 7) % 2) * 2048)
            + longint'(((uw >> 25) % 64) * 32) + longint'(((uw >> 8) % 16) * 2);
        end
        7'h37, 7'h17: begin fmt_o = 3'd4; v = (si >>> 12) * 4096; end
        7'h6F: begin
          fmt_o = 3'd5;
          v = (si >>> 31) * 1048576 + longint'(((uw >> 12) % 256) * 4096)
            + longint'(((uw >> 20) % 2) * 2048) + longint'(((uw >> 21) % 1024) * 2);
        end
        7'h33, 7'h0F: ;
        7'h3B: ill_o = (xlen != 64);
        default: ill_o = 1'b1;
      endcase
    end
    imm_o = (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_outputs();
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    logic        hv;
    logic        er;
    hv = (exp_q.size() > 0);
    er = (exp_q.size() < 2);
    ei = '0; ef = '0; el = 1'b0;
    if (hv) ref_decode(exp_q[0], 32, ei, ef, el);
    check("ov32", {63'b0, ov32}, {63'b0, hv});
    check("rdy32", {63'b0, rdy32}, {63'b0, er});
    check("imm32", {32'b0, imm32}, ei);
    check("fmt32", {61'b0, fmt32}, {61'b0, ef});
    check("ill32", {63'b0, ill32}, {63'b0, el});
    check("cnt32", {48'b0, cnt32}, 64'(min_i(ill_n32, 65535)));
    ei = '0; ef = '0; el = 1'b0;
    if (hv) ref_decode(exp_q[0], 64, ei, ef, el);
    check("ov64", {63'b0, ov64}, {63'b0, hv});
    check("rdy64", {63'b0, rdy64}, {63'b0, er});
    check("imm64", imm64, ei);
    check("fmt64", {61'b0, fmt64}, {61'b0, ef});
    check("ill64", {63'b0, ill64}, {63'b0, el});
    check("cnt64", {48'b0, cnt64}, 64'(min_i(ill_n64, 65535)));
    check("ovs", {63'b0, ovs}, {63'b0, hv});
    check("cnts", {62'b0, cnts}, 64'(min_i(ill_n32, 3)));
  endtask

  // ------------------------------------------------------------ drivers
  // Starts and ends on a falling edge; checks the state seen before the edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy);
    logic        push, pop;
    logic [63:0] di;
    logic [2:0]  df;
    logic        dl;
    in_valid  = v;
    instr     = w;
    out_ready = ordy;
    check_outputs();
    push = v && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && ordy;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(w);
      ref_decode(w, 32, di, df, dl);
      if (dl) ill_n32++;
      ref_decode(w, 64, di, df, dl);
      if (dl) ill_n64++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic v, input logic [31:0] w);
    in_valid = v;
    instr    = w;
    reset    = 1'b1;
    @(posedge clk);
    exp_q.delete();
    ill_n32 = 0;
    ill_n64 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [31:0] w;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic        ill_a;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic        ill_b;
  } vec_t;

  vec_t vt[16];
  logic [6:0] ops[16];

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    //          word          imm (XLEN=32) f  il  imm (XLEN=64)          f  il
    vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0};
    vt[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0};
    vt[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3, 0, 64'hFFFFFFFFFFFFFFF8, 3, 0};
    vt[3]  = '{32'h001000EF, 32'h00000800, 5, 0, 64'h0000000000000800, 5, 0};
    vt[4]  = '{32'h123452B7, 32'h12345000, 4, 0, 64'h0000000012345000, 4, 0};
    vt[5]  = '{32'h800002B7, 32'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0};
    vt[6]  = '{32'h03F09093, 32'h0000001F, 6, 0, 64'h000000000000003F, 6, 0};
    vt[7]  = '{32'h4030D093, 32'h00000003, 6, 0, 64'h0000000000000003, 6, 0};
    vt[8]  = '{32'h00000000, 32'h00000000, 0, 1, 64'h0000000000000000, 0, 1};
    vt[9]  = '{32'h003100B3, 32'h00000000, 0, 0, 64'h0000000000000000, 0, 0};
    vt[10] = '{32'hFFF0809B, 32'h00000000, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0};
    vt[11] = '{32'h01F0909B, 32'h00000000, 0, 1, 64'h000000000000001F, 6, 0};
    vt[12] = '{32'h002080BB, 32'h00000000, 0, 1, 64'h0000000000000000, 0, 0};
    vt[13] = '{32'hFFF00090, 32'h00000000, 0, 1, 64'h0000000000000000, 0, 1};
    vt[14] = '{32'h00000073, 32'h00000000, 1, 0, 64'h0000000000000000, 1, 0};
    vt[15] = '{32'h80002F83, 32'hFFFFF800, 1, 0, 64'hFFFFFFFFFFFFF800, 1, 0};
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h0F, 7'h3B, 7'h00, 7'h7F, 7'h2B};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ov", {63'b0, ov32}, 64'd0);
    check("rst_rdy", {63'b0, rdy32}, 64'd1);
    check("rst_imm", {32'b0, imm32}, 64'd0);
    check("rst_fmt", {61'b0, fmt32}, 64'd0);
    check("rst_cnt", {48'b0, cnt32}, 64'd0);

    // Table vectors: push into an empty FIFO, head visible the next cycle
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, vt[i].w, 1'b1);
      check($sformatf("vec%0d_ov", i), {63'b0, ov32}, 64'd1);
      check($sformatf("vec%0d_imm32", i), {32'b0, imm32}, {32'b0, vt[i].imm_a});
      check($sformatf("vec%0d_fmt32", i), {61'b0, fmt32}, {61'b0, vt[i].fmt_a});
      check($sformatf("vec%0d_ill32", i), {63'b0, ill32}, {63'b0, vt[i].ill_a});
      check($sformatf("vec%0d_imm64", i), imm64, vt[i].imm_b);
      check($sformatf("vec%0d_fmt64", i), {61'b0, fmt64}, {61'b0, vt[i].fmt_b});
      check($sformatf("vec%0d_ill64", i), {63'b0, ill64}, {63'b0, vt[i].ill_b});
      cycle(1'b0, 32'h0, 1'b1);
    end

    // Back-pressure: A, B accepted, C held until space frees up
    do_reset(1'b0, 32'h0);
    cycle(1'b1, 32'hFFF00093, 1'b0);
    cycle(1'b1, 32'hFE112E23, 1'b0);
    check("bp_full_rdy", {63'b0, rdy32}, 64'd0);
    check("bp_head_fmt", {61'b0, fmt32}, 64'd1);
    cycle(1'b1, 32'h123452B7, 1'b0);
    check("bp_hold_imm", {32'b0, imm32}, 64'hFFFFFFFF);
    check("bp_hold_fmt", {61'b0, fmt32}, 64'd1);
    cycle(1'b1, 32'h123452B7, 1'b1);
    check("bp_second_fmt", {61'b0, fmt32}, 64'd2);
    check("bp_second_rdy", {63'b0, rdy32}, 64'd1);
    cycle(1'b1, 32'h123452B7, 1'b1);
    check("bp_pushpop_ov", {63'b0, ov32}, 64'd1);
    check("bp_pushpop_rdy", {63'b0, rdy32}, 64'd1);
    check("bp_third_imm", {32'b0, imm32}, 64'h12345000);
    cycle(1'b0, 32'h0, 1'b1);
    check("bp_drained", {63'b0, ov32}, 64'd0);

    // Illegal counting and saturation
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("ill_cnt32", {48'b0, cnt32}, 64'd5);
    check("ill_cnt_sat", {62'b0, cnts}, 64'd3);

    // Reset with two entries queued and a word offered
    cycle(1'b1, 32'hFFF00093, 1'b0);
    cycle(1'b1, 32'h00000000, 1'b0);
    do_reset(1'b1, 32'hFE112E23);
    check("mid_rst_ov", {63'b0, ov32}, 64'd0);
    check("mid_rst_rdy", {63'b0, rdy32}, 64'd1);
    check("mid_rst_cnt", {48'b0, cnt32}, 64'd0);
    check("mid_rst_cnts", {62'b0, cnts}, 64'd0);
    check("mid_rst_fmt", {61'b0, fmt32}, 64'd0);
    cycle(1'b0, 32'h0, 1'b1);

    // Randomised traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      logic [31:0] r;
      logic [31:0] w;
      r = $urandom();
      if ($urandom_range(0, 7) == 0) w = r;
      else w = {r[31:7], ops[$urandom_range(0, 15)]};
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) < 6);
    end
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
